// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - RV32I arithmetic issue/collect front-end for a single-cycle ALU
module alu_issue_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [WIDTH-1:0] in_rs1,
  input  logic [WIDTH-1:0] in_rs2,
  output logic [WIDTH-1:0] alu_opA,
  output logic [WIDTH-1:0] alu_opB,
  output logic [4:0]       alu_opcode,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic             out_illegal
);

  localparam logic [4:0] OP_ADD = 5'b00000;
  localparam logic [4:0] OP_SUB = 5'b00001;
  localparam logic [4:0] OP_AND = 5'b00010;
  localparam logic [4:0] OP_OR  = 5'b00011;
  localparam logic [4:0] OP_XOR = 5'b00100;
  localparam logic [4:0] OP_SRL = 5'b00101;
  localparam logic [4:0] OP_SLL = 5'b00111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_DONE
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_opa;
  logic [WIDTH-1:0] r_opb;
  logic [4:0]       r_opcode;
  logic             r_illegal;
  logic [WIDTH-1:0] r_out_result;
  logic             r_out_zero;
  logic             r_out_illegal;
  logic             r_out_valid;

  logic             w_in_ready;
  logic             w_accept;
  logic             w_is_r;
  logic             w_is_i;
  logic [2:0]       w_funct3;
  logic [6:0]       w_funct7;
  logic [WIDTH-1:0] w_imm_s;
  logic [WIDTH-1:0] w_imm_sh;
  logic [WIDTH-1:0] w_b_raw;
  logic             w_ok;
  logic             w_shift;
  logic [4:0]       w_opc_dec;
  logic [WIDTH-1:0] w_opa;
  logic [WIDTH-1:0] w_opb;
  logic [4:0]       w_opc;
  logic             w_illegal;
  logic             w_unused_fields;

  // rd and rs1 register indices are resolved upstream; only the values arrive here
  assign w_unused_fields = ^{in_instr[19:15], in_instr[11:7]};

  assign w_is_r   = (in_instr[6:0] == 7'b0110011);
  assign w_is_i   = (in_instr[6:0] == 7'b0010011);
  assign w_funct3 = in_instr[14:12];
  assign w_funct7 = in_instr[31:25];
  assign w_imm_s  = {{(WIDTH-12){in_instr[31]}}, in_instr[31:20]};
  assign w_imm_sh = {{(WIDTH-5){1'b0}}, in_instr[24:20]};

  always_comb begin
    w_ok      = 1'b0;
    w_shift   = 1'b0;
    w_opc_dec = OP_ADD;
    w_b_raw   = w_is_i ? w_imm_s : in_rs2;
    case (w_funct3)
      3'b000: begin
        w_ok      = 1'b1;
        w_opc_dec = (w_is_r && in_instr[30]) ? OP_SUB : OP_ADD;
      end
      3'b100: begin
        w_ok      = 1'b1;
        w_opc_dec = OP_XOR;
      end
      3'b110: begin
        w_ok      = 1'b1;
        w_opc_dec = OP_OR;
      end
      3'b111: begin
        w_ok      = 1'b1;
        w_opc_dec = OP_AND;
      end
      3'b001: begin
        w_ok      = (w_funct7 == 7'b0000000);
        w_shift   = 1'b1;
        w_opc_dec = OP_SLL;
        w_b_raw   = w_is_i ? w_imm_sh : in_rs2;
      end
      3'b101: begin
        // SRA/SRAI (funct7=0100000) has no ALU encoding and is rejected here
        w_ok      = (w_funct7 == 7'b0000000);
        w_shift   = 1'b1;
        w_opc_dec = OP_SRL;
        w_b_raw   = w_is_i ? w_imm_sh : in_rs2;
      end
      default: w_ok = 1'b0;
    endcase
    w_ok = w_ok && (w_is_r || w_is_i);

    w_opa     = '0;
    w_opb     = '0;
    w_opc     = OP_ADD;
    w_illegal = 1'b1;
    if (w_ok) begin
      w_opa     = in_rs1;
      w_opb     = w_shift ? {{(WIDTH-5){1'b0}}, w_b_raw[4:0]} : w_b_raw;
      w_opc     = w_opc_dec;
      w_illegal = 1'b0;
    end
  end

  always_comb begin
    w_in_ready  = 1'b0;
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: w_in_ready = 1'b1;
      ST_DONE: w_in_ready = out_ready;
      default: w_in_ready = 1'b0;
    endcase
    w_in_ready = w_in_ready && rst_n;
    w_accept   = in_valid && w_in_ready;
    case (r_state)
      ST_IDLE: if (w_accept) w_state_nxt = ST_EXEC;
      ST_EXEC: w_state_nxt = ST_DONE;
      ST_DONE: begin
        if (out_ready) w_state_nxt = w_accept ? ST_EXEC : ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_opa         <= '0;
      r_opb         <= '0;
      r_opcode      <= OP_ADD;
      r_illegal     <= 1'b0;
      r_out_result  <= '0;
      r_out_zero    <= 1'b0;
      r_out_illegal <= 1'b0;
      r_out_valid   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_opa     <= w_opa;
        r_opb     <= w_opb;
        r_opcode  <= w_opc;
        r_illegal <= w_illegal;
      end
      case (r_state)
        ST_EXEC: begin
          r_out_result  <= r_illegal ? '0 : alu_result;
          r_out_zero    <= r_illegal ? 1'b1 : alu_zero;
          r_out_illegal <= r_illegal;
          r_out_valid   <= 1'b1;
        end
        ST_DONE: if (out_ready) r_out_valid <= 1'b0;
        default: ;
      endcase
    end
  end

  assign in_ready    = w_in_ready;
  assign alu_opA     = r_opa;
  assign alu_opB     = r_opb;
  assign alu_opcode  = r_opcode;
  assign out_valid   = r_out_valid;
  assign out_result  = r_out_result;
  assign out_zero    = r_out_zero;
  assign out_illegal = r_out_illegal;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb/tb_alu_issue_ctrl.sv - directed self-checking bench for alu_issue_ctrl
module tb_alu_issue_ctrl;
  localparam int WIDTH = 32;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_instr;
  logic [WIDTH-1:0] in_rs1;
  logic [WIDTH-1:0] in_rs2;
  logic [WIDTH-1:0] alu_opA;
  logic [WIDTH-1:0] alu_opB;
  logic [4:0]       alu_opcode;
  logic [WIDTH-1:0] alu_result;
  logic             alu_zero;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic             out_zero;
  logic             out_illegal;

  int n_checks = 0;
  int n_fail   = 0;

  alu_issue_ctrl #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_instr   (in_instr),
    .in_rs1     (in_rs1),
    .in_rs2     (in_rs2),
    .alu_opA    (alu_opA),
    .alu_opB    (alu_opB),
    .alu_opcode (alu_opcode),
    .alu_result (alu_result),
    .alu_zero   (alu_zero),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_zero   (out_zero),
    .out_illegal(out_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // single-cycle ALU stand-in
  always_comb begin
    case (alu_opcode)
      5'b00000: alu_result = alu_opA + alu_opB;
      5'b00001: alu_result = alu_opA - alu_opB;
      5'b00010: alu_result = alu_opA & alu_opB;
      5'b00011: alu_result = alu_opA | alu_opB;
      5'b00100: alu_result = alu_opA ^ alu_opB;
      5'b00101: alu_result = alu_opA >> alu_opB[4:0];
      5'b00111: alu_result = alu_opA << alu_opB[4:0];
      default:  alu_result = '0;
    endcase
    alu_zero = (alu_result == '0);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue from IDLE, check ALU drive, result, then retire with one out_ready cycle.
  task automatic do_op(input string tag, input logic [31:0] instr,
                       input logic [31:0] rs1, input logic [31:0] rs2,
                       input logic [4:0] e_opc, input logic [31:0] e_opa,
                       input logic [31:0] e_opb, input logic [31:0] e_res,
                       input logic e_zero, input logic e_ill);
    @(negedge clk);
    in_valid = 1'b1; in_instr = instr; in_rs1 = rs1; in_rs2 = rs2;
    chk({tag, ".in_ready"}, 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    chk({tag, ".opcode"}, 64'(alu_opcode), 64'(e_opc));
    chk({tag, ".opA"}, 64'(alu_opA), 64'(e_opa));
    chk({tag, ".opB"}, 64'(alu_opB), 64'(e_opb));
    chk({tag, ".exec_valid"}, 64'(out_valid), 64'd0);
    @(negedge clk);
    chk({tag, ".out_valid"}, 64'(out_valid), 64'd1);
    chk({tag, ".result"}, 64'(out_result), 64'(e_res));
    chk({tag, ".zero"}, 64'(out_zero), 64'(e_zero));
    chk({tag, ".illegal"}, 64'(out_illegal), 64'(e_ill));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, ".retired"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; in_rs1 = '0; in_rs2 = '0; out_ready = 1'b0;
    #2;
    chk("rst.in_ready", 64'(in_ready), 64'd0);
    chk("rst.out_valid", 64'(out_valid), 64'd0);
    chk("rst.opA", 64'(alu_opA), 64'd0);
    chk("rst.opcode", 64'(alu_opcode), 64'd0);
    chk("rst.result", 64'(out_result), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    do_op("add",  32'h00000033, 32'd5,      32'd7,      5'b00000, 32'd5,      32'd7,        32'd12,       1'b0, 1'b0);
    do_op("sub",  32'h40000033, 32'h1234,   32'h1234,   5'b00001, 32'h1234,   32'h1234,     32'd0,        1'b1, 1'b0);
    do_op("addi", 32'hFFF00013, 32'd0,      32'd99,     5'b00000, 32'd0,      32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0);
    do_op("slli", 32'h00401013, 32'd3,      32'd0,      5'b00111, 32'd3,      32'd4,        32'h30,       1'b0, 1'b0);
    do_op("srl",  32'h00005033, 32'h100,    32'h24,     5'b00101, 32'h100,    32'd4,        32'h10,       1'b0, 1'b0);
    do_op("sra",  32'h40005033, 32'h100,    32'd4,      5'b00000, 32'd0,      32'd0,        32'd0,        1'b1, 1'b1);
    do_op("ori",  32'h0F006013, 32'h0F,     32'd0,      5'b00011, 32'h0F,     32'hF0,       32'hFF,       1'b0, 1'b0);
    do_op("andi", 32'hFF007013, 32'h1234,   32'd0,      5'b00010, 32'h1234,   32'hFFFFFFF0, 32'h1230,     1'b0, 1'b0);
    do_op("xor",  32'h00004033, 32'hF0F0,   32'hFF00,   5'b00100, 32'hF0F0,   32'hFF00,     32'h0FF0,     1'b0, 1'b0);
    do_op("slt",  32'h00002033, 32'd1,      32'd2,      5'b00000, 32'd0,      32'd0,        32'd0,        1'b1, 1'b1);
    do_op("load", 32'h00000003, 32'd1,      32'd2,      5'b00000, 32'd0,      32'd0,        32'd0,        1'b1, 1'b1);

    // back-pressure: second instruction waits behind an unread result
    @(negedge clk);
    in_valid = 1'b1; in_instr = 32'h00000033; in_rs1 = 32'd1; in_rs2 = 32'd2;
    @(negedge clk);
    in_instr = 32'h40000033; in_rs1 = 32'd10; in_rs2 = 32'd3;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk("bp.in_ready", 64'(in_ready), 64'd0);
      chk("bp.out_valid", 64'(out_valid), 64'd1);
      chk("bp.result", 64'(out_result), 64'd3);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    chk("bp.in_ready_follows", 64'(in_ready), 64'd1);
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b0;
    chk("bp.valid_drop", 64'(out_valid), 64'd0);
    chk("bp.opcode2", 64'(alu_opcode), 64'd1);
    chk("bp.opA2", 64'(alu_opA), 64'd10);
    @(negedge clk);
    chk("bp.valid2", 64'(out_valid), 64'd1);
    chk("bp.result2", 64'(out_result), 64'd7);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // asynchronous reset during EXEC
    in_valid = 1'b1; in_instr = 32'h00000033; in_rs1 = 32'd8; in_rs2 = 32'd9;
    @(negedge clk);
    in_valid = 1'b0;
    chk("ar.opA_before", 64'(alu_opA), 64'd8);
    #2 rst_n = 1'b0;
    #1;
    chk("ar.opA", 64'(alu_opA), 64'd0);
    chk("ar.opB", 64'(alu_opB), 64'd0);
    chk("ar.out_valid", 64'(out_valid), 64'd0);
    chk("ar.out_result", 64'(out_result), 64'd0);
    chk("ar.in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("ar.no_pulse", 64'(out_valid), 64'd0);
    end
    do_op("post", 32'h00000033, 32'd20, 32'd22, 5'b00000, 32'd20, 32'd22, 32'd42, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
